// File: rtl/oldland_sram_responder.sv
// On-chip word memory serving the Oldland instruction fetch port (read-only, always ready)
// and the byte-lane data port with an optional fixed wait-state sequencer.
module oldland_sram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  input  logic        d_access,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error
);

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wr_val;
  logic [3:0]  r_req_bytesel;
  logic        r_req_wr_en;
  logic        r_ack;
  logic        r_error;

  logic                 w_accept;
  logic                 w_perform;
  logic [31:0]          w_addr;
  logic [31:0]          w_wr_val;
  logic [3:0]           w_bytesel;
  logic                 w_wr_en;
  logic                 w_d_in_range;
  logic                 w_i_in_range;
  logic [ADDR_BITS-1:0] w_d_idx;
  logic [ADDR_BITS-1:0] w_i_idx;
  logic [3:0]           w_lane_we;
  logic                 w_rd_load;
  logic                 w_rd_clear;

  assign w_accept = (r_state == S_IDLE) && d_access && !rst;

  // Zero wait states act on the live request; otherwise the latched copy is used.
  assign w_perform = !rst && ((WAIT_STATES == 0) ? w_accept
                                                 : ((r_state == S_WAIT) && (r_cnt == 4'd1)));
  assign w_addr    = (WAIT_STATES == 0) ? d_addr    : r_req_addr;
  assign w_wr_val  = (WAIT_STATES == 0) ? d_wr_val  : r_req_wr_val;
  assign w_bytesel = (WAIT_STATES == 0) ? d_bytesel : r_req_bytesel;
  assign w_wr_en   = (WAIT_STATES == 0) ? d_wr_en   : r_req_wr_en;

  assign w_d_in_range = (w_addr >> (ADDR_BITS + 2)) == 32'd0;
  assign w_i_in_range = (i_addr >> (ADDR_BITS + 2)) == 32'd0;
  assign w_d_idx      = w_addr[ADDR_BITS+1:2];
  assign w_i_idx      = i_addr[ADDR_BITS+1:2];

  assign w_rd_clear = w_perform && !w_d_in_range;
  assign w_rd_load  = w_perform && w_d_in_range && !w_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_ack   <= w_perform;
      r_error <= w_perform && !w_d_in_range;
      case (r_state)
        S_IDLE: begin
          if (d_access) begin
            r_req_addr    <= d_addr;
            r_req_wr_val  <= d_wr_val;
            r_req_bytesel <= d_bytesel;
            r_req_wr_en   <= d_wr_en;
            if (WAIT_STATES != 0) begin
              r_state <= S_WAIT;
              r_cnt   <= WS;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // One byte-wide array per lane keeps byte-enable writes a plain RAM pattern.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [0:DEPTH-1];
      logic [7:0] r_i_byte;
      logic [7:0] r_d_byte;

      assign w_lane_we[gi] = w_perform && w_d_in_range && w_wr_en && w_bytesel[gi];

      always_ff @(posedge clk) begin
        if (w_lane_we[gi]) begin
          r_mem[w_d_idx] <= w_wr_val[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_i_byte <= 8'h00;
        end else if (w_i_in_range) begin
          r_i_byte <= r_mem[w_i_idx];
        end else begin
          r_i_byte <= 8'h00;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_d_byte <= 8'h00;
        end else if (w_rd_clear) begin
          r_d_byte <= 8'h00;
        end else if (w_rd_load) begin
          r_d_byte <= r_mem[w_d_idx];
        end
      end

      assign i_data[8*gi +: 8] = r_i_byte;
      assign d_data[8*gi +: 8] = r_d_byte;
    end
  endgenerate

  assign d_ack   = r_ack;
  assign d_error = r_error;

endmodule

// File: tb/tb_oldland_sram_responder.sv
// Bench for oldland_sram_responder: three instances (0, 3 and 2 wait states) driven by
// directed and random requests, checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_oldland_sram_responder;

  localparam int AB = 12;
  localparam int NI = 3;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [NI];
  logic [31:0] i_addr   [NI];
  logic [31:0] i_data   [NI];
  logic [31:0] d_addr   [NI];
  logic [3:0]  d_bytesel[NI];
  logic        d_wr_en  [NI];
  logic [31:0] d_wr_val [NI];
  logic        d_access [NI];
  logic [31:0] d_data   [NI];
  logic        d_ack    [NI];
  logic        d_error  [NI];

  int checks = 0;
  int errors = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      oldland_sram_responder #(.ADDR_BITS(AB), .WAIT_STATES(ws_of(gi))) u_dut (
        .clk(clk), .rst(rst[gi]), .i_addr(i_addr[gi]), .i_data(i_data[gi]),
        .d_addr(d_addr[gi]), .d_bytesel(d_bytesel[gi]), .d_wr_en(d_wr_en[gi]),
        .d_wr_val(d_wr_val[gi]), .d_access(d_access[gi]), .d_data(d_data[gi]),
        .d_ack(d_ack[gi]), .d_error(d_error[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int];
  bit          p_valid[NI];
  int          p_due  [NI];
  bit          p_wr   [NI];
  logic [31:0] p_addr [NI];
  logic [31:0] p_val  [NI];
  logic [3:0]  p_be   [NI];
  bit          e_valid[NI];
  logic [31:0] e_i    [NI];
  logic [31:0] e_d    [NI];
  bit          e_i_known[NI];
  bit          e_d_known[NI];
  bit          e_ack  [NI];
  bit          e_err  [NI];
  int          edge_no = 0;

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> (AB + 2)) == 32'd0;
  endfunction

  function automatic int key_of(input int k, input logic [31:0] a);
    return k * (1 << AB) + int'((a >> 2) & ((32'd1 << AB) - 32'd1));
  endfunction

  task automatic model_access(input int k, input bit wr, input logic [31:0] a,
                              input logic [31:0] v, input logic [3:0] be);
    int key;
    logic [31:0] w;
    key = key_of(k, a);
    e_ack[k] = 1'b1;
    if (!in_rng(a)) begin
      e_d[k] = 32'h0;
      e_d_known[k] = 1'b1;
      e_err[k] = 1'b1;
    end else if (wr) begin
      if (be == 4'hF || m_mem.exists(key)) begin
        w = m_mem.exists(key) ? m_mem[key] : 32'h0;
        for (int l = 0; l < 4; l++) begin
          if (be[l]) w[8*l +: 8] = v[8*l +: 8];
        end
        m_mem[key] = w;
      end
    end else begin
      e_d_known[k] = m_mem.exists(key);
      if (m_mem.exists(key)) e_d[k] = m_mem[key];
    end
    $display("[dut%0d ws=%0d] edge %0d %s addr=%h wval=%h be=%h err=%0d", k, ws_of(k), edge_no,
             wr ? "WR" : "RD", a, v, be, e_err[k]);
  endtask

  task automatic model_step(input int k);
    int key;
    e_valid[k] = 1'b1;
    if (rst[k]) begin
      e_i[k] = 32'h0; e_d[k] = 32'h0;
      e_i_known[k] = 1'b1; e_d_known[k] = 1'b1;
      e_ack[k] = 1'b0; e_err[k] = 1'b0;
      p_valid[k] = 1'b0;
    end else begin
      if (in_rng(i_addr[k])) begin
        key = key_of(k, i_addr[k]);
        e_i_known[k] = m_mem.exists(key);
        if (m_mem.exists(key)) e_i[k] = m_mem[key];
      end else begin
        e_i[k] = 32'h0;
        e_i_known[k] = 1'b1;
      end
      e_ack[k] = 1'b0;
      e_err[k] = 1'b0;
      if (p_valid[k]) begin
        if (edge_no == p_due[k]) begin
          p_valid[k] = 1'b0;
          model_access(k, p_wr[k], p_addr[k], p_val[k], p_be[k]);
        end
      end else if (d_access[k] === 1'b1) begin
        if (ws_of(k) == 0) begin
          model_access(k, d_wr_en[k], d_addr[k], d_wr_val[k], d_bytesel[k]);
        end else begin
          p_valid[k] = 1'b1;
          p_due[k]   = edge_no + ws_of(k);
          p_wr[k]    = d_wr_en[k];
          p_addr[k]  = d_addr[k];
          p_val[k]   = d_wr_val[k];
          p_be[k]    = d_bytesel[k];
        end
      end
    end
  endtask

  // Compare DUT against the model at every falling edge, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (e_valid[k]) begin
          check1($sformatf("dut%0d d_ack", k), d_ack[k], e_ack[k]);
          check1($sformatf("dut%0d d_error", k), d_error[k], e_err[k]);
          if (e_i_known[k]) check($sformatf("dut%0d i_data", k), i_data[k], e_i[k]);
          if (e_d_known[k]) check($sformatf("dut%0d d_data", k), d_data[k], e_d[k]);
        end
      end
      edge_no++;
      for (int k = 0; k < NI; k++) model_step(k);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit acc, input bit wr, input logic [31:0] a,
                       input logic [31:0] v, input logic [3:0] be);
    d_access[k] = acc; d_wr_en[k] = wr; d_addr[k] = a; d_wr_val[k] = v; d_bytesel[k] = be;
  endtask

  task automatic transact(input int k, input bit wr, input logic [31:0] a, input logic [31:0] v,
                          input logic [3:0] be, output logic [31:0] rd, output logic er);
    bit got;
    got = 1'b0;
    rd = 'x;
    er = 'x;
    drive(k, 1'b1, wr, a, v, be);
    step();
    d_access[k] = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (d_ack[k] === 1'b1) begin
        got = 1'b1;
        rd = d_data[k];
        er = d_error[k];
      end
    end
    check1($sformatf("dut%0d ack within budget", k), got, 1'b1);
    step();
  endtask

  task automatic fetch(input int k, input logic [31:0] a, output logic [31:0] val);
    i_addr[k] = a;
    @(posedge clk);
    @(negedge clk);
    val = i_data[k];
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom | 32'h0001_0000;
    return 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; i_addr[k] = 32'h0;
      drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("dut%0d reset i_data", k), i_data[k], 32'h0);
      check($sformatf("dut%0d reset d_data", k), d_data[k], 32'h0);
      check1($sformatf("dut%0d reset d_ack", k), d_ack[k], 1'b0);
      check1($sformatf("dut%0d reset d_error", k), d_error[k], 1'b0);
    end
    step();
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    step();

    // Back-to-back write then read, no wait states.
    drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clk);
    check1("t1 write ack", d_ack[0], 1'b1);
    step();
    d_access[0] = 1'b0;
    @(negedge clk);
    check1("t1 read ack", d_ack[0], 1'b1);
    check("t1 read data", d_data[0], 32'hDEADBEEF);
    step();

    // Byte lanes with an unaligned read address.
    transact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er);
    transact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er);
    transact(0, 0, 32'h23, 32'h0, 4'h0, rd, er);
    check("t2 lane merge", rd, 32'h11BB33DD);
    check1("t2 no error", er, 1'b0);

    // Out of range: 0x4000 would alias word 0 without the range check.
    transact(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er);
    transact(0, 1'b1, 32'h4000, 32'h12345678, 4'hF, rd, er);
    check1("t4 oob write error", er, 1'b1);
    transact(0, 0, 32'h0, 32'h0, 4'hF, rd, er);
    check("t4 word0 intact", rd, 32'h0BADF00D);
    transact(0, 0, 32'h4000, 32'h0, 4'hF, rd, er);
    check("t4 oob read data", rd, 32'h0);
    check1("t4 oob read error", er, 1'b1);
    fetch(0, 32'h0, rd);
    check("t4 fetch word0", rd, 32'h0BADF00D);
    fetch(0, 32'h4000, rd);
    check("t4 fetch oob", rd, 32'h0);

    // Instruction fetch and data write to the same word on the same edge.
    transact(0, 1'b1, 32'h40, 32'h1, 4'hF, rd, er);
    i_addr[0] = 32'h40;
    drive(0, 1'b1, 1'b1, 32'h40, 32'h2, 4'hF);
    step();
    d_access[0] = 1'b0;
    @(negedge clk);
    check("t5 read-first", i_data[0], 32'h1);
    @(negedge clk);
    check("t5 new value", i_data[0], 32'h2);
    step();

    // Three wait states; requests pulsed during WAIT are ignored.
    transact(1, 1'b1, 32'h100, 32'hCAFE0003, 4'hF, rd, er);
    drive(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step();
    for (int j = 0; j < 8; j++) begin
      d_access[1] = (j <= 2);
      @(negedge clk);
      check1($sformatf("t3 ack cycle %0d", j), d_ack[1], j == 3);
      if (j == 3) check("t3 read data", d_data[1], 32'hCAFE0003);
      step();
    end
    d_access[1] = 1'b0;

    // Reset one cycle after a write is accepted, two wait states.
    transact(2, 1'b1, 32'h8, 32'h11111111, 4'hF, rd, er);
    transact(2, 0, 32'h8, 32'h0, 4'hF, rd, er);
    check("t6 preload", rd, 32'h11111111);
    i_addr[2] = 32'h8;
    drive(2, 1'b1, 1'b1, 32'h8, 32'h55, 4'hF);
    step();
    d_access[2] = 1'b0;
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    @(negedge clk);
    check("t6 i_data after reset", i_data[2], 32'h0);
    check("t6 d_data after reset", d_data[2], 32'h0);
    check1("t6 d_error after reset", d_error[2], 1'b0);
    for (int j = 0; j < 4; j++) begin
      check1($sformatf("t6 no ack %0d", j), d_ack[2], 1'b0);
      @(negedge clk);
    end
    step();
    transact(2, 0, 32'h8, 32'h0, 4'hF, rd, er);
    check("t6 word unchanged", rd, 32'h11111111);

    // Random traffic on a small window plus out-of-range addresses.
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 16; w++) begin
        transact(k, 1'b1, 32'h200 + 32'(4 * w), $urandom, 4'hF, rd, er);
      end
      repeat (120) begin
        a = rand_addr();
        i_addr[k] = ($urandom_range(0, 1) == 0) ? a : rand_addr();
        transact(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, er);
      end
    end

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
